audio_adc_recorder: RTL and testbench
=====================================

// Module: audio_adc_recorder
// PURPOSE
// Record-path stage feeding the SRAM port of the recorder/player top level. Samples the
// WM8731 I2S ADC stream (BCLK/ADCLRCK/ADCDAT, codec master) in the CLK50 domain and
// deserialises the left-channel 16-bit word. Writes one word per frame to sequential SRAM
// addresses. Tracks recording length; SRAM_ADDR[17:13] of this block drives the time display.
// PARAMETERS
// DATA_W     16  sample width, bits shifted per left channel
// ADDR_W     18  SRAM address width; last address = 2**ADDR_W-1
// WE_CYCLES  2   CLK50 cycles WE_N is held low per write (>=1)
// PORTS
// CLK50    in   1       50 MHz system clock, all logic on rising edge
// RST_N    in   1       asynchronous active-low reset
// START    in   1       1-cycle pulse: begin recording from address 0
// PAUSE    in   1       level: suspend capture, keep address
// STOP     in   1       1-cycle pulse: end recording, return to IDLE
// BCLK     in   1       codec bit clock (async to CLK50, period >= 4 CLK50 cycles)
// ADCLRCK  in   1       codec ADC frame clock; low = left channel
// ADCDAT   in   1       codec ADC serial data, MSB first
// ADDR     out  ADDR_W  SRAM write address
// WDATA    out  DATA_W  SRAM write data
// WE_N     out  1       SRAM write enable, active low
// BUSY     out  1       1 in any state except IDLE/FULL
// FULL     out  1       1 once last address has been written
// LEN      out  ADDR_W+1 number of words written in current recording
// BEHAVIOUR
// Reset: state IDLE; ADDR=0, WDATA=0, WE_N=1, BUSY=0, FULL=0, LEN=0, shift reg=0.
// BCLK, ADCLRCK, ADCDAT each pass a 2-FF synchroniser; a third register gives edge detect.
//  Synchronised BCLK rise is flagged 3 CLK50 cycles after pad edge; ADCDAT equally delayed.
// States:
//  IDLE: START -> WAIT_LR, ADDR=0, LEN=0, FULL=0. Other inputs ignored.
//  WAIT_LR: wait for synced ADCLRCK falling edge; if PAUSE=1 edge ignored (stay).
//   On accepted edge -> SKIP.
//  SKIP: ignore first BCLK rise (I2S 1-bit delay) -> SHIFT, bit count=0.
//  SHIFT: each BCLK rise: shift <= {shift[DATA_W-2:0], ADCDAT_sync}, count++.
//   After DATA_W-th bit -> WRITE next cycle; right-channel bits never shifted.
//  WRITE: WDATA=shift, WE_N=0 for exactly WE_CYCLES cycles, ADDR stable throughout.
//   Last cycle: WE_N->1 next cycle; LEN<=LEN+1.
//   If ADDR==2**ADDR_W-1 -> FULL (ADDR held, FULL=1); else ADDR<=ADDR+1 -> WAIT_LR.
//  FULL: no writes; only STOP (-> IDLE) leaves; START ignored.
// PAUSE is sampled only in WAIT_LR: a sample already in SKIP/SHIFT completes and is written.
// STOP has priority over everything in every state, including mid-WRITE:
//  next cycle WE_N=1, state IDLE, ADDR=0, FULL=0; LEN keeps count of completed writes.
// START and STOP same cycle: STOP wins. START outside IDLE ignored.
// Async RST_N mid-write forces WE_N=1 immediately (no clock needed).
// LEN width ADDR_W+1 so full memory (2**ADDR_W) is representable; no wrap.
// WDATA holds last written word until next WRITE; it is not cleared by STOP.
// TESTING
// 1 START, one frame left=0xA5C3 right=0xFFFF -> single write ADDR=0 WDATA=0xA5C3, WE_N low 2 cycles, LEN=1.
// 2 START, frames 0x0001,0x8000,0x7FFF -> writes at ADDR 0,1,2 in order, LEN=3, ADDR=3, BUSY=1.
// 3 ADDR_W=3, 9 frames -> 8 writes, FULL=1, BUSY=0, ADDR=7, 9th frame no WE_N pulse; STOP -> IDLE, FULL=0.
// 4 STOP after 8 of 16 bits -> no write, IDLE, ADDR=0, LEN keeps prior value; START+STOP same cycle -> stays IDLE.
// 5 PAUSE raised mid-SHIFT of frame 2 -> frame 2 written at ADDR=1, next 3 frames skipped; release -> next frame at ADDR=2.
// 6 RST_N low during WRITE -> WE_N=1 same cycle, all outputs reset values; BCLK jitter 4-6 CLK50 period still captures bits exactly.

Source files
------------

// File: rtl/audio_adc_recorder.sv
// Record-path stage: captures the left-channel word of a WM8731 I2S ADC stream
// (codec is bus master) and writes one word per frame to consecutive SRAM addresses.
module audio_adc_recorder #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 18,
    parameter int WE_CYCLES = 2
) (
    input  logic              CLK50,
    input  logic              RST_N,
    input  logic              START,
    input  logic              PAUSE,
    input  logic              STOP,
    input  logic              BCLK,
    input  logic              ADCLRCK,
    input  logic              ADCDAT,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] WDATA,
    output logic              WE_N,
    output logic              BUSY,
    output logic              FULL,
    output logic [ADDR_W:0]   LEN,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT_LR = 3'd1,
        S_SKIP    = 3'd2,
        S_SHIFT   = 3'd3,
        S_WRITE   = 3'd4,
        S_FULL    = 3'd5
    } state_t;

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int WE_W  = $clog2(WE_CYCLES + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(DATA_W - 1);
    localparam logic [WE_W-1:0]   LAST_WE   = WE_W'(WE_CYCLES - 1);

    state_t             state_q;
    state_t             state_d;
    logic [2:0]         bclk_q;
    logic [2:0]         lrck_q;
    logic [1:0]         dat_q;
    logic [DATA_W-1:0]  shift_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic [WE_W-1:0]    we_cnt;
    logic               bclk_rise;
    logic               lrck_fall;
    logic [DATA_W-1:0]  shift_next;

    // Two flops resynchronise the pads, the third stage is only for edge detection.
    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            bclk_q <= '0;
            lrck_q <= '0;
            dat_q  <= '0;
        end else begin
            bclk_q <= {bclk_q[1:0], BCLK};
            lrck_q <= {lrck_q[1:0], ADCLRCK};
            dat_q  <= {dat_q[0], ADCDAT};
        end
    end

    assign bclk_rise  = bclk_q[1] & ~bclk_q[2];
    assign lrck_fall  = ~lrck_q[1] & lrck_q[2];
    assign shift_next = {shift_q[DATA_W-2:0], dat_q[1]};

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (START) state_d = S_WAIT_LR;
            S_WAIT_LR: if (lrck_fall && !PAUSE) state_d = S_SKIP;
            S_SKIP:    if (bclk_rise) state_d = S_SHIFT;
            S_SHIFT:   if (bclk_rise && bit_cnt == LAST_BIT) state_d = S_WRITE;
            S_WRITE:   if (we_cnt == LAST_WE) state_d = (ADDR == ADDR_LAST) ? S_FULL : S_WAIT_LR;
            S_FULL:    state_d = S_FULL;
            default:   state_d = S_IDLE;
        endcase
        if (STOP) state_d = S_IDLE;
    end

    // WE_N decodes straight from the state register so an async reset releases it at once.
    always_comb begin
        WE_N      = (state_q != S_WRITE);
        BUSY      = (state_q != S_IDLE) && (state_q != S_FULL);
        FULL      = (state_q == S_FULL);
        dbg_state = state_q;
    end

    always_ff @(posedge CLK50 or negedge RST_N) begin
        if (!RST_N) begin
            ADDR    <= '0;
            WDATA   <= '0;
            LEN     <= '0;
            shift_q <= '0;
            bit_cnt <= '0;
            we_cnt  <= '0;
        end else if (STOP) begin
            ADDR <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (START) begin
                        ADDR <= '0;
                        LEN  <= '0;
                    end
                end
                S_SKIP: begin
                    if (bclk_rise) bit_cnt <= '0;
                end
                S_SHIFT: begin
                    if (bclk_rise) begin
                        shift_q <= shift_next;
                        bit_cnt <= bit_cnt + 1'b1;
                        // Latch the word with its final bit so WDATA is valid from the first WE_N cycle.
                        if (bit_cnt == LAST_BIT) begin
                            WDATA  <= shift_next;
                            we_cnt <= '0;
                        end
                    end
                end
                S_WRITE: begin
                    we_cnt <= we_cnt + 1'b1;
                    if (we_cnt == LAST_WE) begin
                        LEN <= LEN + 1'b1;
                        if (ADDR != ADDR_LAST) ADDR <= ADDR + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_audio_adc_recorder.sv
// Bench for audio_adc_recorder: a jittery I2S codec driver, a frame-level model of which
// frames should land in SRAM, and a WE_N monitor that scores every write against it.
module tb_audio_adc_recorder;

    localparam int AW       = 3;
    localparam int DW       = 16;
    localparam int WEC      = 2;
    localparam int EW       = AW + DW + 4;
    localparam int MAX_ADDR = (1 << AW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          pause = 1'b0;
    logic          stop = 1'b0;
    logic          bclk = 1'b1;
    logic          adclrck = 1'b1;
    logic          adcdat = 1'b0;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          we_n;
    logic          busy;
    logic          full;
    logic [AW:0]   len;
    logic [2:0]    dbg_state;

    audio_adc_recorder #(.DATA_W(DW), .ADDR_W(AW), .WE_CYCLES(WEC)) dut (
        .CLK50(clk), .RST_N(rst_n), .START(start), .PAUSE(pause), .STOP(stop),
        .BCLK(bclk), .ADCLRCK(adclrck), .ADCDAT(adcdat),
        .ADDR(addr), .WDATA(wdata), .WE_N(we_n), .BUSY(busy), .FULL(full),
        .LEN(len), .dbg_state(dbg_state)
    );

    always #10 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout exp finish");
        $fatal(1);
    end

    // Scoreboard entries: {addr, data, WE_N low cycles}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] exp_e;
    int            n_vec = 0;
    int            n_err = 0;

    bit            m_rec;
    bit            m_full;
    int            m_addr;
    int            m_len;
    logic [DW-1:0] m_wdata;
    bit            carry;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".addr"}, 32'(addr), 32'(m_addr));
        check({tag, ".len"}, 32'(len), 32'(m_len));
        check({tag, ".busy"}, 32'(busy), 32'(m_rec && !m_full));
        check({tag, ".full"}, 32'(full), 32'(m_full));
        check({tag, ".wdata"}, 32'(wdata), 32'(m_wdata));
        check({tag, ".we_n"}, 32'(we_n), 32'd1);
    endtask

    task automatic model_start();
        if (!m_rec) begin
            m_rec  = 1'b1;
            m_addr = 0;
            m_len  = 0;
            m_full = 1'b0;
        end
    endtask

    task automatic model_stop();
        m_rec  = 1'b0;
        m_addr = 0;
        m_full = 1'b0;
    endtask

    task automatic model_reset();
        model_stop();
        m_len   = 0;
        m_wdata = '0;
    endtask

    // A frame is stored only if recording, not full, and PAUSE is low as the frame begins.
    task automatic model_frame(input logic [DW-1:0] left);
        if (m_rec && !m_full && !pause) begin
            exp_q.push_back({AW'(m_addr), left, 4'(WEC)});
            m_len++;
            m_wdata = left;
            if (m_addr == MAX_ADDR) m_full = 1'b1;
            else m_addr++;
        end
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_stop();
        @(negedge clk); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
    endtask

    task automatic pulse_both();
        @(negedge clk); start = 1'b1; stop = 1'b1;
        @(negedge clk); start = 1'b0; stop = 1'b0;
    endtask

    task automatic settle();
        repeat (10) @(negedge clk);
    endtask

    // 32 BCLK periods: LRCK low for the first 16, each bit driven on BCLK fall, MSB one period late.
    task automatic send_frame(input logic [DW-1:0] left, input logic [DW-1:0] right,
                              input int pause_at, input int stop_at);
        logic [31:0] bits;
        bits = {carry, left, right[DW-1:1]};
        @(posedge clk); #3;
        for (int p = 0; p < 32; p++) begin
            if (p == stop_at) begin
                stop = 1'b1;
                @(posedge clk); #3;
                stop = 1'b0;
            end
            if (p == pause_at) pause = 1'b1;
            bclk    = 1'b0;
            adclrck = (p >= 16);
            adcdat  = bits[31-p];
            #(20 * $urandom_range(2, 3));
            bclk = 1'b1;
            #(20 * $urandom_range(2, 3));
        end
        carry = right[0];
    endtask

    task automatic record_frame(input logic [DW-1:0] left);
        model_frame(left);
        send_frame(left, DW'($urandom), -1, -1);
    endtask

    int            run = 0;
    logic [AW-1:0] cap_a;
    logic [DW-1:0] cap_d;

    always @(negedge clk) begin
        if (!we_n) begin
            if (run == 0) begin
                cap_a = addr;
                cap_d = wdata;
            end else begin
                check("we_addr_hold", 32'(addr), 32'(cap_a));
                check("we_data_hold", 32'(wdata), 32'(cap_d));
            end
            run++;
        end else if (run != 0) begin
            if (exp_q.size() == 0) begin
                check("write_expected", 32'(exp_q.size()), 32'd1);
            end else begin
                exp_e = exp_q.pop_front();
                check("wr_addr", 32'(cap_a), 32'(exp_e[EW-1 -: AW]));
                check("wr_data", 32'(cap_d), 32'(exp_e[DW+3:4]));
                check("wr_cycles", 32'(run), 32'(exp_e[3:0]));
            end
            run = 0;
        end
    end

    logic [DW-1:0] t2_words[3] = '{16'h0001, 16'h8000, 16'h7FFF};
    logic [DW-1:0] t6_left;

    initial begin
        m_rec = 1'b0; m_full = 1'b0; m_addr = 0; m_len = 0; m_wdata = '0; carry = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;
        settle();

        // Single frame
        pulse_start(); model_start();
        model_frame(16'hA5C3);
        send_frame(16'hA5C3, 16'hFFFF, -1, -1);
        settle(); check_outputs("t1");
        pulse_stop(); model_stop();
        settle(); check_outputs("t1_stop");

        // Three boundary words in sequence
        pulse_start(); model_start();
        foreach (t2_words[i]) record_frame(t2_words[i]);
        settle(); check_outputs("t2");
        pulse_stop(); model_stop();

        // Fill the memory, one extra frame, START ignored in FULL, then STOP
        pulse_start(); model_start();
        for (int i = 0; i < 9; i++) record_frame(DW'($urandom));
        settle(); check_outputs("t3_full");
        pulse_start(); model_start();
        settle(); check_outputs("t3_start_ign");
        pulse_stop(); model_stop();
        settle(); check_outputs("t3_stop");

        // STOP halfway through a word, then START and STOP together
        pulse_start(); model_start();
        record_frame(DW'($urandom));
        send_frame(DW'($urandom), DW'($urandom), -1, 9);
        model_stop();
        settle(); check_outputs("t4_stop");
        pulse_both();
        settle(); check_outputs("t4_both");

        // PAUSE raised while frame 2 shifts, held for three frames
        pulse_start(); model_start();
        record_frame(DW'($urandom));
        t6_left = DW'($urandom);
        model_frame(t6_left);
        send_frame(t6_left, DW'($urandom), 10, -1);
        for (int i = 0; i < 3; i++) record_frame(DW'($urandom));
        pause = 1'b0;
        record_frame(DW'($urandom));
        settle(); check_outputs("t5");
        pulse_stop(); model_stop();

        // Random pause pattern across frames
        pulse_start(); model_start();
        for (int i = 0; i < 10; i++) begin
            pause = ($urandom_range(0, 3) == 0);
            record_frame(DW'($urandom));
            pause = 1'b0;
            settle(); check_outputs("rand");
        end
        pulse_stop(); model_stop();
        settle(); check_outputs("rand_stop");

        // Asynchronous reset during the write strobe
        pulse_start(); model_start();
        t6_left = DW'($urandom);
        exp_q.push_back({AW'(m_addr), t6_left, 4'd1});
        fork
            send_frame(t6_left, DW'($urandom), -1, -1);
            begin
                for (int i = 0; i < 2000 && we_n; i++) @(negedge clk);
                check("t6_we_seen", 32'(we_n), 32'd0);
                #2 rst_n = 1'b0;
                #1 model_reset();
                check_outputs("t6_rst");
            end
        join
        settle(); check_outputs("t6_hold");
        rst_n = 1'b1;
        settle(); check_outputs("t6_release");

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
